// File: rtl/led_mode_ctrl_if.sv
// Button/LED bundle between the board-level test or top and led_mode_ctrl.
// The master drives the debounced buttons; the slave (the controller) drives the LED side.
interface led_mode_ctrl_if;
    logic [3:0] btn_stable;
    logic [3:0] led_out;
    logic [2:0] mode;
    logic       running;
    logic       step;

    modport master (output btn_stable, input led_out, mode, running, step);
    modport slave  (input btn_stable, output led_out, mode, running, step);
endinterface

// File: rtl/led_mode_ctrl.sv
// LED animation controller: mode, speed and run/pause driven by debounced active-low buttons.
// Optional auto-repeat for the speed buttons is enabled with LED_MODE_CTRL_AUTOREPEAT_EN.
//
// mode     | meaning
// ---------+----------------------------------------------
// 0 OFF    | all LEDs dark, step still pulses
// 1 BLINK  | all LEDs, inverted every step
// 2 SHIFT  | single LED rotating left
// 3 BOUNCE | single LED walking up then down
// 4 COUNT  | 4-bit binary up-count
// 5..7     | unreachable, behave as OFF
module led_mode_ctrl #(
    parameter int unsigned TICK_DIV   = 25_000,
    parameter int unsigned REPEAT_DLY = 500_000
) (
    input  logic           clk,
    input  logic           rst_n,
    led_mode_ctrl_if.slave bus
);
    localparam logic [2:0] M_OFF    = 3'd0;
    localparam logic [2:0] M_BLINK  = 3'd1;
    localparam logic [2:0] M_SHIFT  = 3'd2;
    localparam logic [2:0] M_BOUNCE = 3'd3;
    localparam logic [2:0] M_COUNT  = 3'd4;

    logic [3:0]  btn_prev;
    logic [3:0]  press_raw;
    logic [3:0]  press;
    logic [3:0]  pat;
    logic [3:0]  pat_start;
    logic [3:0]  pat_step;
    logic [3:0]  led_q;
    logic [2:0]  mode_q;
    logic [2:0]  mode_next;
    logic [1:0]  speed;
    logic [31:0] presc;
    logic [31:0] period;
    logic        running_q;
    logic        dir_up;
    logic        dir_next;
    logic        tc;
    logic        mode_chg;
    logic        spd_chg;
    logic        step_int;

    assign press_raw = btn_prev & ~bus.btn_stable;

`ifdef LED_MODE_CTRL_AUTOREPEAT_EN
    logic [31:0] hold_cnt;
    logic        held_one;
    logic        rep;

    // Holding both speed buttons counts as no hold, so they never repeat against each other.
    assign held_one = bus.btn_stable[1] ^ bus.btn_stable[2];
    assign rep      = held_one && (hold_cnt == 32'(REPEAT_DLY - 1));
    assign press    = press_raw | {1'b0, rep & ~bus.btn_stable[2], rep & ~bus.btn_stable[1], 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            hold_cnt <= '0;
        else if (!held_one || rep)
            hold_cnt <= '0;
        else
            hold_cnt <= hold_cnt + 32'd1;
    end
`else
    assign press = press_raw;
`endif

    assign period   = 32'(TICK_DIV) << speed;
    assign tc       = (presc == period - 32'd1);
    assign mode_chg = press[0];
    assign spd_chg  = press[1] | press[2];
    // A mode change in the terminal cycle discards that step.
    assign step_int = running_q & tc & ~mode_chg;

    always_comb begin
        case (mode_q)
            M_OFF:    mode_next = M_BLINK;
            M_BLINK:  mode_next = M_SHIFT;
            M_SHIFT:  mode_next = M_BOUNCE;
            M_BOUNCE: mode_next = M_COUNT;
            M_COUNT:  mode_next = M_OFF;
            default:  mode_next = M_BLINK;
        endcase
    end

    always_comb begin
        case (mode_next)
            M_BLINK:  pat_start = 4'b1111;
            M_SHIFT:  pat_start = 4'b0001;
            M_BOUNCE: pat_start = 4'b0001;
            default:  pat_start = 4'b0000;
        endcase
    end

    always_comb begin
        pat_step = 4'b0000;
        dir_next = dir_up;
        case (mode_q)
            M_BLINK:  pat_step = ~pat;
            M_SHIFT:  pat_step = {pat[2:0], pat[3]};
            M_BOUNCE: begin
                if (dir_up && pat[3]) begin
                    pat_step = pat >> 1;
                    dir_next = 1'b0;
                end else if (!dir_up && pat[0]) begin
                    pat_step = pat << 1;
                    dir_next = 1'b1;
                end else begin
                    pat_step = dir_up ? (pat << 1) : (pat >> 1);
                end
            end
            M_COUNT:  pat_step = pat + 4'd1;
            default:  pat_step = 4'b0000;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_prev  <= 4'b1111;
            led_q     <= 4'b1111;
            mode_q    <= M_OFF;
            running_q <= 1'b1;
            speed     <= 2'd2;
            presc     <= '0;
            pat       <= 4'b0000;
            dir_up    <= 1'b1;
        end else begin
            btn_prev <= bus.btn_stable;
            led_q    <= ~pat;
            if (press[3])
                running_q <= ~running_q;
            if (press[1] && !press[2] && speed != 2'd0)
                speed <= speed - 2'd1;
            else if (press[2] && !press[1] && speed != 2'd3)
                speed <= speed + 2'd1;
            if (mode_chg || spd_chg)
                presc <= '0;
            else if (running_q)
                presc <= tc ? '0 : presc + 32'd1;
            if (mode_chg) begin
                mode_q <= mode_next;
                pat    <= pat_start;
                dir_up <= 1'b1;
            end else if (step_int) begin
                pat    <= pat_step;
                dir_up <= dir_next;
            end
        end
    end

    assign bus.led_out = led_q;
    assign bus.mode    = mode_q;
    assign bus.running = running_q;
    assign bus.step    = step_int;
endmodule
